// File: rtl/usb_phy_func_switch.sv
// usb_phy_func_switch
//   Shares one bit-banged USB full-speed PHY (DP, DN, DP pull-up) among
//   N_FUNC USB function cores. A change of the requested function detaches
//   from the host (pull-up off, pads undriven), holds every core in reset,
//   swaps the owner, keeps the cores in reset a little longer, then lets the
//   new owner re-attach.
//
//   state   | meaning
//   --------+---------------------------------------------------------------
//   RUN     | active function owns the pads, its reset is released
//   DETACH  | pull-up off, pads released, DETACH_CYCLES cycles so host sees it
//   SWITCH  | one cycle, active_sel takes the latched target
//   RELEASE | RESET_CYCLES cycles of core reset before the new owner runs
//
// Ports
//   i_clk, i_rst          clock, asynchronous active-high reset
//   i_sel_req             requested function (values >= N_FUNC are ignored)
//   i_func_dp_o/_t        per-function DP drive value / enable
//   i_func_dn_o/_t        per-function DN drive value / enable
//   i_func_dp_pull        per-function DP pull-up request
//   o_func_dp_i/_dn_i     pad inputs, routed to the active function only
//   o_func_rst_n          per-function reset, active low, registered
//   i_phy_dp_i/_dn_i      pad inputs
//   o_phy_dp_o/_t         DP pad drive value / enable
//   o_phy_dn_o/_t         DN pad drive value / enable
//   o_phy_dp_pull         DP 1.5k pull-up control
//   o_active_sel          function currently owning the PHY
//   o_busy                1 in any state other than RUN
//   o_sel_err             1 the cycle after an out-of-range i_sel_req
module usb_phy_func_switch #(
    parameter int N_FUNC        = 2,
    parameter int DEFAULT_SEL   = 0,
    parameter int DETACH_CYCLES = 600000,
    parameter int RESET_CYCLES  = 16,
    localparam int SEL_W        = (N_FUNC > 1) ? $clog2(N_FUNC) : 1
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic [SEL_W-1:0]  i_sel_req,
    input  logic [N_FUNC-1:0] i_func_dp_o,
    input  logic [N_FUNC-1:0] i_func_dp_t,
    input  logic [N_FUNC-1:0] i_func_dn_o,
    input  logic [N_FUNC-1:0] i_func_dn_t,
    input  logic [N_FUNC-1:0] i_func_dp_pull,
    output logic [N_FUNC-1:0] o_func_dp_i,
    output logic [N_FUNC-1:0] o_func_dn_i,
    output logic [N_FUNC-1:0] o_func_rst_n,
    input  logic              i_phy_dp_i,
    input  logic              i_phy_dn_i,
    output logic              o_phy_dp_o,
    output logic              o_phy_dp_t,
    output logic              o_phy_dn_o,
    output logic              o_phy_dn_t,
    output logic              o_phy_dp_pull,
    output logic [SEL_W-1:0]  o_active_sel,
    output logic              o_busy,
    output logic              o_sel_err
);

    localparam int CNT_MAX = (DETACH_CYCLES > RESET_CYCLES) ? DETACH_CYCLES : RESET_CYCLES;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    localparam logic [CNT_W-1:0] DETACH_LAST = CNT_W'(DETACH_CYCLES - 1);
    localparam logic [CNT_W-1:0] RESET_LAST  = CNT_W'(RESET_CYCLES - 1);
    localparam logic [SEL_W-1:0] DEF_SEL     = SEL_W'(DEFAULT_SEL);

    typedef enum logic [1:0] {
        ST_RUN,
        ST_DETACH,
        ST_SWITCH,
        ST_RELEASE
    } state_t;

    state_t            r_state;
    logic [CNT_W-1:0]  r_cnt;
    logic [SEL_W-1:0]  r_active_sel;
    logic [SEL_W-1:0]  r_target;
    logic [N_FUNC-1:0] r_func_rst_n;
    logic              r_sel_err;

    logic              w_run;
    logic              w_sel_legal;

    function automatic logic [N_FUNC-1:0] one_hot(input logic [SEL_W-1:0] sel);
        logic [N_FUNC-1:0] v;
        v      = '0;
        v[sel] = 1'b1;
        return v;
    endfunction

    // Widen before comparing so N_FUNC values that fill SEL_W exactly still work.
    assign w_sel_legal = (32'(i_sel_req) < $unsigned(N_FUNC));

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state      <= ST_RELEASE;
            r_cnt        <= '0;
            r_active_sel <= DEF_SEL;
            r_target     <= DEF_SEL;
            r_func_rst_n <= '0;
            r_sel_err    <= 1'b0;
        end else begin
            r_sel_err <= ~w_sel_legal;
            case (r_state)
                ST_RUN: begin
                    if (w_sel_legal && (i_sel_req != r_active_sel)) begin
                        r_state      <= ST_DETACH;
                        r_target     <= i_sel_req;
                        r_cnt        <= '0;
                        r_func_rst_n <= '0;
                    end
                end
                ST_DETACH: begin
                    if (r_cnt == DETACH_LAST) begin
                        r_state <= ST_SWITCH;
                        r_cnt   <= '0;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                ST_SWITCH: begin
                    r_active_sel <= r_target;
                    r_cnt        <= '0;
                    r_state      <= ST_RELEASE;
                end
                ST_RELEASE: begin
                    if (r_cnt == RESET_LAST) begin
                        r_state      <= ST_RUN;
                        r_cnt        <= '0;
                        r_func_rst_n <= one_hot(r_active_sel);
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                default: begin
                    r_state <= ST_RELEASE;
                    r_cnt   <= '0;
                end
            endcase
        end
    end

    assign w_run = (r_state == ST_RUN);

    // Only the active function's pad controls are ever selected, and only in RUN.
    assign o_phy_dp_o    = w_run & i_func_dp_o[r_active_sel];
    assign o_phy_dp_t    = w_run & i_func_dp_t[r_active_sel];
    assign o_phy_dn_o    = w_run & i_func_dn_o[r_active_sel];
    assign o_phy_dn_t    = w_run & i_func_dn_t[r_active_sel];
    assign o_phy_dp_pull = w_run & i_func_dp_pull[r_active_sel];

    always_comb begin
        o_func_dp_i = '0;
        o_func_dn_i = '0;
        if (w_run) begin
            o_func_dp_i[r_active_sel] = i_phy_dp_i;
            o_func_dn_i[r_active_sel] = i_phy_dn_i;
        end
    end

    assign o_func_rst_n = r_func_rst_n;
    assign o_active_sel = r_active_sel;
    assign o_busy       = ~w_run;
    assign o_sel_err    = r_sel_err;

endmodule

// File: tb/tb_usb_phy_func_switch.sv
// Directed bench for usb_phy_func_switch with N_FUNC=3, DEFAULT_SEL=0,
// DETACH_CYCLES=20, RESET_CYCLES=4.
module tb_usb_phy_func_switch;

    localparam int N_FUNC = 3;
    localparam int SEL_W  = 2;

    logic              clk;
    logic              rst;
    logic [SEL_W-1:0]  sel_req;
    logic [N_FUNC-1:0] func_dp_o, func_dp_t, func_dn_o, func_dn_t, func_dp_pull;
    logic [N_FUNC-1:0] func_dp_i, func_dn_i, func_rst_n;
    logic              phy_dp_i, phy_dn_i;
    logic              phy_dp_o, phy_dp_t, phy_dn_o, phy_dn_t, phy_dp_pull;
    logic [SEL_W-1:0]  active_sel;
    logic              busy, sel_err;
    logic [4:0]        pads;

    int n_checks = 0;
    int n_fails  = 0;
    int n;

    usb_phy_func_switch #(
        .N_FUNC(3), .DEFAULT_SEL(0), .DETACH_CYCLES(20), .RESET_CYCLES(4)
    ) dut (
        .i_clk(clk), .i_rst(rst), .i_sel_req(sel_req),
        .i_func_dp_o(func_dp_o), .i_func_dp_t(func_dp_t),
        .i_func_dn_o(func_dn_o), .i_func_dn_t(func_dn_t),
        .i_func_dp_pull(func_dp_pull),
        .o_func_dp_i(func_dp_i), .o_func_dn_i(func_dn_i), .o_func_rst_n(func_rst_n),
        .i_phy_dp_i(phy_dp_i), .i_phy_dn_i(phy_dn_i),
        .o_phy_dp_o(phy_dp_o), .o_phy_dp_t(phy_dp_t),
        .o_phy_dn_o(phy_dn_o), .o_phy_dn_t(phy_dn_t),
        .o_phy_dp_pull(phy_dp_pull), .o_active_sel(active_sel),
        .o_busy(busy), .o_sel_err(sel_err)
    );

    // {pull, dp_o, dp_t, dn_o, dn_t}
    assign pads = {phy_dp_pull, phy_dp_o, phy_dp_t, phy_dn_o, phy_dn_t};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
        end
    endtask

    // Counts edges until busy drops; 0 means it never did within the bound.
    task automatic wait_run(output int cycles);
        cycles = 0;
        for (int k = 1; k <= 100; k++) begin
            @(posedge clk); #1;
            if (!busy) begin
                cycles = k;
                break;
            end
        end
    endtask

    initial begin
        // f0 = 11110, f1 = 10111, f2 = 11001 on {pull,dp_o,dp_t,dn_o,dn_t}
        rst          = 1'b1;
        sel_req      = 2'd0;
        func_dp_pull = 3'b111;
        func_dp_o    = 3'b101;
        func_dp_t    = 3'b011;
        func_dn_o    = 3'b011;
        func_dn_t    = 3'b110;
        phy_dp_i     = 1'b1;
        phy_dn_i     = 1'b0;

        #12;
        check("rst_busy",   32'(busy),       32'd1);
        check("rst_rstn",   32'(func_rst_n), 32'd0);
        check("rst_pads",   32'(pads),       32'd0);
        check("rst_active", 32'(active_sel), 32'd0);
        check("rst_selerr", 32'(sel_err),    32'd0);
        check("rst_dpi",    32'(func_dp_i),  32'd0);

        @(negedge clk);
        rst = 1'b0;
        n = 0;
        for (int k = 1; k <= 100; k++) begin
            @(posedge clk); #1;
            if (!busy) begin
                n = k;
                break;
            end
            check("rel_rstn", 32'(func_rst_n), 32'd0);
        end
        check("rel_len",   n,                32'd4);
        check("run0_rstn", 32'(func_rst_n),  32'b001);
        check("run0_pads", 32'(pads),        32'b11110);
        check("run0_dpi",  32'(func_dp_i),   32'b001);
        check("run0_dni",  32'(func_dn_i),   32'b000);

        // out-of-range request
        sel_req = 2'd3;
        @(posedge clk); #1;
        check("err_set",    32'(sel_err),    32'd1);
        check("err_busy",   32'(busy),       32'd0);
        check("err_active", 32'(active_sel), 32'd0);
        check("err_pads",   32'(pads),       32'b11110);
        repeat (3) @(posedge clk);
        #1;
        check("err_hold",   32'(busy),       32'd0);
        sel_req = 2'd0;
        @(posedge clk); #1;
        check("err_clr",    32'(sel_err),    32'd0);

        // switch 0 -> 2, request changes to 1 in the middle of DETACH
        sel_req = 2'd2;
        @(posedge clk); #1;
        check("det_busy", 32'(busy),       32'd1);
        check("det_pads", 32'(pads),       32'd0);
        check("det_rstn", 32'(func_rst_n), 32'd0);
        check("det_dpi",  32'(func_dp_i),  32'd0);
        n = 0;
        for (int k = 1; k <= 100; k++) begin
            @(posedge clk); #1;
            if (k == 4)  sel_req = 2'd1;
            if (k == 10) check("det_active", 32'(active_sel), 32'd0);
            if (k == 21) begin
                check("relz_active", 32'(active_sel), 32'd2);
                check("relz_rstn",   32'(func_rst_n), 32'd0);
            end
            if (!busy) begin
                n = k;
                break;
            end
        end
        check("sw2_len",    n,               32'd25);
        check("sw2_active", 32'(active_sel), 32'd2);
        check("sw2_rstn",   32'(func_rst_n), 32'b100);
        check("sw2_pads",   32'(pads),       32'b11001);
        check("sw2_dpi",    32'(func_dp_i),  32'b100);

        // pending request for 1 starts a fresh switch after one RUN cycle
        @(posedge clk); #1;
        check("sw1_start", 32'(busy),       32'd1);
        check("sw1_rstn0", 32'(func_rst_n), 32'd0);
        wait_run(n);
        check("sw1_len",    n,               32'd25);
        check("sw1_active", 32'(active_sel), 32'd1);
        check("sw1_rstn",   32'(func_rst_n), 32'b010);
        check("sw1_pads",   32'(pads),       32'b10111);

        // other functions drive hard; only function 1 may reach the pads
        func_dp_o    = 3'b101;
        func_dp_t    = 3'b111;
        func_dn_o    = 3'b101;
        func_dn_t    = 3'b111;
        func_dp_pull = 3'b101;
        phy_dn_i     = 1'b1;
        #1;
        check("iso_pads", 32'(pads),      32'b00101);
        check("iso_dpi",  32'(func_dp_i), 32'b010);
        check("iso_dni",  32'(func_dn_i), 32'b010);
        phy_dn_i = 1'b0;

        // async reset during DETACH cycle 10
        sel_req = 2'd0;
        @(posedge clk); #1;
        check("rd_busy", 32'(busy), 32'd1);
        repeat (9) @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        check("ar_busy",   32'(busy),       32'd1);
        check("ar_rstn",   32'(func_rst_n), 32'd0);
        check("ar_active", 32'(active_sel), 32'd0);
        check("ar_pads",   32'(pads),       32'd0);
        @(negedge clk);
        rst = 1'b0;
        wait_run(n);
        check("ar_len",     n,               32'd4);
        check("ar_active2", 32'(active_sel), 32'd0);
        check("ar_rstn2",   32'(func_rst_n), 32'b001);
        check("ar_pads2",   32'(pads),       32'b11111);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
